// File: rtl/terrain_gen_if.sv
// Request/response bundle for the terrain height map: regeneration and crater
// requests, a direct column write, a registered read port and busy/done status.
interface terrain_gen_if #(
   parameter int CW = 10,
   parameter int HW = 10
);
   logic          gen_start;
   logic          gen_mode;
   logic [15:0]   seed;
   logic          crater_start;
   logic [CW-1:0] crater_col;
   logic [5:0]    crater_radius;
   logic          wr_en;
   logic [CW-1:0] wr_col;
   logic [HW-1:0] wr_height;
   logic [CW-1:0] rd_col;
   logic [HW-1:0] rd_height;
   logic          busy;
   logic          done;

   modport master (
      output gen_start, gen_mode, seed,
      output crater_start, crater_col, crater_radius,
      output wr_en, wr_col, wr_height,
      output rd_col,
      input  rd_height, busy, done
   );

   modport slave (
      input  gen_start, gen_mode, seed,
      input  crater_start, crater_col, crater_radius,
      input  wr_en, wr_col, wr_height,
      input  rd_col,
      output rd_height, busy, done
   );
endinterface

// File: rtl/terrain_gen.sv
// Column height map for a destructible-terrain playfield. Each column stores the
// row of its topmost solid pixel. The map is (re)generated one column per cycle,
// either flat or from a smoothed LFSR noise walk, and can be deformed by craters
// (read-modify-write over a column range) or by direct single-column writes.
module terrain_gen #(
   parameter int NCOLS          = 640,
   parameter int NROWS          = 480,
   parameter int HW             = 10,
   parameter int DEFAULT_HEIGHT = 310,
   parameter int MIN_H          = 64,
   parameter int BIAS           = 53
) (
   input logic          clk,
   input logic          reset,
   terrain_gen_if.slave bus
);
   localparam int CW = $clog2(NCOLS);

   localparam logic [CW-1:0]        LAST_COL = CW'(NCOLS - 1);
   localparam logic [CW:0]          NCOLS_X  = (CW+1)'(NCOLS);
   localparam logic [CW:0]          LAST_X   = (CW+1)'(NCOLS - 1);
   localparam logic [HW-1:0]        DEF_H    = HW'(DEFAULT_HEIGHT);
   localparam logic [HW-1:0]        MIN_HV   = HW'(MIN_H);
   localparam logic [HW-1:0]        FLOOR_HV = HW'(NROWS - 1);
   localparam logic signed [HW+1:0] MIN_S    = (HW+2)'(MIN_H);
   localparam logic signed [HW+1:0] FLOOR_S  = (HW+2)'(NROWS - 1);
   localparam logic [HW:0]          FLOOR_U  = (HW+1)'(NROWS - 1);
   localparam logic signed [9:0]    BIAS_S   = 10'(BIAS);
   localparam logic [15:0]          SEED_ALT = 16'hACE1;

   // Keep a generated height inside the playable band [MIN_H, floor row].
   function automatic logic [HW-1:0] clamp_h(input logic signed [HW+1:0] v);
      logic [HW-1:0] r;
      if (v < MIN_S)
         r = MIN_HV;
      else if (v > FLOOR_S)
         r = FLOOR_HV;
      else
         r = v[HW-1:0];
      return r;
   endfunction

   // Crater growth never pushes a column below the floor row.
   function automatic logic [HW-1:0] sat_floor(input logic [HW:0] v);
      logic [HW-1:0] r;
      if (v > FLOOR_U)
         r = FLOOR_HV;
      else
         r = v[HW-1:0];
      return r;
   endfunction

   typedef enum logic [1:0] {GEN, IDLE, CR_RD, CR_WR} state_t;

   state_t state_q, state_d;

   logic [HW-1:0] mem [NCOLS];

   // generator state
   logic                 mode_q;
   logic [15:0]          lfsr_q;
   logic signed [9:0]    noise_q;
   logic [HW-1:0]        hgt_q;
   logic [CW-1:0]        col_q;

   // crater state
   logic [CW-1:0]        cr_c_q;
   logic [CW-1:0]        cr_x_q;
   logic [CW-1:0]        cr_hi_q;
   logic [5:0]           cr_r_q;
   logic                 cr_empty_q;
   logic [HW-1:0]        cr_rdata_q;

   // outputs and FSM strobes
   logic                 done_q, done_d;
   logic [HW-1:0]        rd_q;
   logic                 gen_acc, cr_acc;
   logic                 mem_we;
   logic [CW-1:0]        mem_addr;
   logic [HW-1:0]        mem_wdata;

   // generator next-values
   logic                 fb;
   logic [15:0]          lfsr_nxt;
   logic signed [9:0]    n1, n2, n3, rng_t, nstep, noise_nxt;
   logic signed [HW+1:0] hsum;
   logic [HW-1:0]        hgt_nxt;

   // crater range and write value
   logic [CW-1:0]        cr_r_ext, cr_lo, cr_hi;
   logic [CW:0]          cr_sum;
   logic                 cr_empty;
   logic [CW-1:0]        cr_dist, cr_add;
   logic [HW-1:0]        cr_wdata;

   logic                 wr_ok, rd_ok;

   // Noise walk: smooth the noise with a 7/8 decay plus fresh LFSR bits, and
   // step the height by the top bits of the previous noise value.
   always_comb begin
      fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_nxt  = {lfsr_q[14:0], fb};
      n1        = noise_q >>> 1;
      n2        = noise_q >>> 2;
      n3        = noise_q >>> 3;
      rng_t     = $signed({3'b000, lfsr_q[9:3]});
      noise_nxt = n1 + n2 + n3 + rng_t - BIAS_S;
      nstep     = noise_q >>> 7;
      hsum      = $signed({2'b00, hgt_q}) + (HW+2)'(nstep);
      hgt_nxt   = clamp_h(hsum);
   end

   // Crater column range at request time, clipped to the screen edges.
   always_comb begin
      cr_r_ext = CW'(bus.crater_radius);
      cr_lo    = (bus.crater_col >= cr_r_ext) ? bus.crater_col - cr_r_ext : '0;
      cr_sum   = {1'b0, bus.crater_col} + {1'b0, cr_r_ext};
      cr_hi    = (cr_sum > LAST_X) ? LAST_COL : cr_sum[CW-1:0];
      cr_empty = ({1'b0, bus.crater_col} >= NCOLS_X);
   end

   // Crater deepening: closer to the centre means a larger push toward the floor.
   always_comb begin
      cr_dist  = (cr_x_q >= cr_c_q) ? cr_x_q - cr_c_q : cr_c_q - cr_x_q;
      cr_add   = CW'(cr_r_q) - cr_dist;
      cr_wdata = sat_floor({1'b0, cr_rdata_q} + (HW+1)'(cr_add));
      wr_ok    = ({1'b0, bus.wr_col} < NCOLS_X);
      rd_ok    = ({1'b0, bus.rd_col} < NCOLS_X);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= GEN;
      else
         state_q <= state_d;
   end

   // FSM next state, request arbitration and memory write selection.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      gen_acc   = 1'b0;
      cr_acc    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (bus.gen_start) begin
               gen_acc = 1'b1;
               state_d = GEN;
            end else if (bus.crater_start) begin
               cr_acc  = 1'b1;
               state_d = CR_RD;
            end else if (bus.wr_en && wr_ok) begin
               mem_we    = 1'b1;
               mem_addr  = bus.wr_col;
               mem_wdata = bus.wr_height;
            end
         end
         GEN: begin
            mem_we    = 1'b1;
            mem_addr  = col_q;
            mem_wdata = mode_q ? hgt_q : DEF_H;
            if (col_q == LAST_COL) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         CR_RD: begin
            if (cr_empty_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = CR_WR;
            end
         end
         CR_WR: begin
            mem_we    = 1'b1;
            mem_addr  = cr_x_q;
            mem_wdata = cr_wdata;
            if (cr_x_q == cr_hi_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = CR_RD;
            end
         end
         default: state_d = GEN;
      endcase
   end

   // Generator registers: seeded on request, advanced once per generated column.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= 1'b1;
         lfsr_q  <= SEED_ALT;
         noise_q <= '0;
         col_q   <= '0;
         hgt_q   <= DEF_H;
      end else if (gen_acc) begin
         mode_q  <= bus.gen_mode;
         lfsr_q  <= (bus.seed == 16'h0000) ? SEED_ALT : bus.seed;
         noise_q <= '0;
         col_q   <= '0;
         hgt_q   <= DEF_H;
      end else if (state_q == GEN) begin
         col_q <= col_q + 1'b1;
         if (mode_q) begin
            lfsr_q  <= lfsr_nxt;
            noise_q <= noise_nxt;
            hgt_q   <= hgt_nxt;
         end
      end
   end

   // Crater registers: range latched on request, column fetched then advanced.
   always_ff @(posedge clk) begin
      if (cr_acc) begin
         cr_c_q     <= bus.crater_col;
         cr_r_q     <= bus.crater_radius;
         cr_x_q     <= cr_lo;
         cr_hi_q    <= cr_hi;
         cr_empty_q <= cr_empty;
      end else if (state_q == CR_RD && !cr_empty_q) begin
         cr_rdata_q <= mem[cr_x_q];
      end else if (state_q == CR_WR) begin
         cr_x_q <= cr_x_q + 1'b1;
      end
   end

   // Height memory write port; writes are suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (mem_we && !reset)
         mem[mem_addr] <= mem_wdata;
   end

   // Registered read port, valid in every state; out-of-range columns read 0.
   always_ff @(posedge clk) begin
      if (reset)
         rd_q <= '0;
      else if (rd_ok)
         rd_q <= mem[bus.rd_col];
      else
         rd_q <= '0;
   end

   // Completion pulse follows the final write of an operation.
   always_ff @(posedge clk) begin
      if (reset)
         done_q <= 1'b0;
      else
         done_q <= done_d;
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.rd_height = rd_q;
endmodule

// File: tb/tb_terrain_gen.sv
// Bench for terrain_gen: directed scenarios plus randomized writes/craters and
// seeded regenerations, compared against an integer height-map model.
module tb_terrain_gen;
   localparam int NC   = 640;
   localparam int NR   = 480;
   localparam int DEF  = 310;
   localparam int MINH = 64;
   localparam int BIAS = 53;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   terrain_gen_if #(.CW(10), .HW(10)) bus ();

   terrain_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int mh  [NC];
   int got [NC];

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      bus.gen_start    = 1'b0;
      bus.crater_start = 1'b0;
      bus.wr_en        = 1'b0;
   endtask

   // Reference: whole-map generation with plain integer arithmetic.
   task automatic model_gen(input bit mode, input logic [15:0] sd);
      logic [15:0] l;
      int n, h, s, st;
      l = (sd == 16'h0000) ? 16'hACE1 : sd;
      n = 0;
      h = DEF;
      for (int c = 0; c < NC; c++) begin
         mh[c] = h;
         if (mode) begin
            st = n >>> 7;
            s  = (n >>> 1) + (n >>> 2) + (n >>> 3) + int'(l[9:3]) - BIAS;
            s  = s & 1023;
            if (s >= 512) s = s - 1024;
            n  = s;
            h  = h + st;
            if (h < MINH) h = MINH;
            if (h > NR - 1) h = NR - 1;
            l  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         end
      end
   endtask

   // Reference: crater deformation; returns the expected busy length.
   task automatic model_crater(input int c, input int r, output int exp_busy);
      int lo, hi, d, v;
      if (c >= NC) begin
         exp_busy = 1;
      end else begin
         lo = (c - r < 0) ? 0 : c - r;
         hi = (c + r > NC - 1) ? NC - 1 : c + r;
         for (int x = lo; x <= hi; x++) begin
            d = (x > c) ? x - c : c - x;
            v = mh[x] + r - d;
            mh[x] = (v > NR - 1) ? NR - 1 : v;
         end
         exp_busy = 2 * (hi - lo + 1);
      end
   endtask

   // Issue the already-driven request and follow it to its done pulse.
   task automatic run_op(input string tag, input int budget, input bit inject, output int busy_n);
      int t;
      busy_n = 0;
      step();
      clear_req();
      t = 1;
      if (bus.busy) busy_n++;
      while (!bus.done && t < budget) begin
         if (inject && t == 2) begin
            bus.wr_en     = 1'b1;
            bus.wr_col    = 10'd400;
            bus.wr_height = 10'd7;
            bus.gen_start = 1'b1;
            bus.gen_mode  = 1'b1;
         end
         step();
         clear_req();
         t++;
         if (bus.busy) busy_n++;
      end
      chk_eq({tag, "_done"}, int'(bus.done), 1);
      chk_eq({tag, "_busy_at_done"}, int'(bus.busy), 0);
      step();
      chk_eq({tag, "_done_pulse"}, int'(bus.done), 0);
   endtask

   task automatic do_gen(input string tag, input bit mode, input logic [15:0] sd);
      int bn;
      bus.gen_start = 1'b1;
      bus.gen_mode  = mode;
      bus.seed      = sd;
      model_gen(mode, sd);
      run_op(tag, 2000, 1'b0, bn);
      chk_eq({tag, "_busy_len"}, bn, NC);
   endtask

   task automatic do_crater(input string tag, input int c, input int r, input bit inject);
      int bn, eb;
      bus.crater_start  = 1'b1;
      bus.crater_col    = 10'(c);
      bus.crater_radius = 6'(r);
      model_crater(c, r, eb);
      run_op(tag, 400, inject, bn);
      chk_eq({tag, "_busy_len"}, bn, eb);
   endtask

   task automatic do_wr(input string tag, input int c, input int h);
      bus.wr_en     = 1'b1;
      bus.wr_col    = 10'(c);
      bus.wr_height = 10'(h);
      step();
      clear_req();
      mh[c] = h;
      chk_eq({tag, "_busy"}, int'(bus.busy), 0);
      chk_eq({tag, "_done"}, int'(bus.done), 0);
   endtask

   task automatic read_col(input int c, output int v);
      bus.rd_col = 10'(c);
      step();
      v = int'(bus.rd_height);
   endtask

   task automatic spot(input string tag, input int c, input int exp);
      int v;
      read_col(c, v);
      chk_eq($sformatf("%s_c%0d", tag, c), v, exp);
   endtask

   task automatic sweep(input string tag);
      for (int c = 0; c < NC; c++) begin
         read_col(c, got[c]);
         chk_eq($sformatf("%s_h%0d", tag, c), got[c], mh[c]);
      end
   endtask

   // Shape properties of a freshly generated noise map, from the read-back values.
   task automatic props(input string tag);
      int rv, dv, d;
      rv = 0;
      dv = 0;
      for (int c = 0; c < NC; c++) begin
         if (got[c] < MINH || got[c] > NR - 1) rv++;
         if (c > 0) begin
            d = got[c] - got[c-1];
            if (d < -4 || d > 3) dv++;
         end
      end
      chk_eq({tag, "_col0"}, got[0], DEF);
      chk_eq({tag, "_range_viol"}, rv, 0);
      chk_eq({tag, "_step_viol"}, dv, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, v, pulses, gaps;
      logic [15:0] sd;

      bus.gen_start     = 1'b0;
      bus.gen_mode      = 1'b0;
      bus.seed          = 16'h0000;
      bus.crater_start  = 1'b0;
      bus.crater_col    = '0;
      bus.crater_radius = '0;
      bus.wr_en         = 1'b0;
      bus.wr_col        = '0;
      bus.wr_height     = '0;
      bus.rd_col        = '0;

      // reset held several cycles, then generation from reset defaults
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_eq($sformatf("rst_busy%0d", i), int'(bus.busy), 1);
         chk_eq($sformatf("rst_done%0d", i), int'(bus.done), 0);
         chk_eq($sformatf("rst_rd%0d", i), int'(bus.rd_height), 0);
      end
      reset = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.done && n < 2000);
      chk_eq("rst_gen_len", n, NC);
      step();
      chk_eq("rst_gen_pulse", int'(bus.done), 0);
      model_gen(1'b1, 16'hACE1);
      sweep("rstgen");
      props("rstgen");

      // flat regeneration
      do_gen("flat", 1'b0, 16'($urandom));
      sweep("flat");

      // crater in the middle of flat terrain
      do_crater("cr100", 100, 5, 1'b0);
      spot("cr100", 100, 315);
      spot("cr100", 97, 312);
      spot("cr100", 103, 312);
      spot("cr100", 95, 310);
      spot("cr100", 105, 310);
      spot("cr100", 94, 310);
      spot("cr100", 106, 310);

      // crater clipped at the left edge
      do_gen("flat2", 1'b0, 16'h1234);
      do_crater("cr2", 2, 5, 1'b0);
      spot("cr2", 0, 313);
      spot("cr2", 7, 310);
      spot("cr2", 8, 310);

      // floor saturation
      do_wr("wr48", 48, 477);
      do_wr("wr49", 49, 477);
      do_wr("wr50", 50, 477);
      do_crater("crsat", 50, 5, 1'b0);
      spot("crsat", 50, 479);
      spot("crsat", 49, 479);
      spot("crsat", 48, 479);
      spot("crsat", 52, mh[52]);

      // empty range and zero radius
      do_crater("crempty", 700, 3, 1'b0);
      do_crater("crr0", 300, 0, 1'b0);
      spot("crr0", 300, mh[300]);

      // same-cycle priority: gen over crater over write
      bus.wr_en         = 1'b1;
      bus.wr_col        = 10'd10;
      bus.wr_height     = 10'd5;
      bus.crater_start  = 1'b1;
      bus.crater_col    = 10'd10;
      bus.crater_radius = 6'd3;
      do_gen("prio_gen", 1'b0, 16'h0001);
      spot("prio_gen", 10, DEF);
      bus.wr_en     = 1'b1;
      bus.wr_col    = 10'd200;
      bus.wr_height = 10'd100;
      do_crater("prio_cr", 200, 2, 1'b0);
      spot("prio_cr", 200, 312);
      spot("prio_cr", 199, 311);
      spot("prio_cr", 202, 310);

      // requests while busy are dropped
      do_crater("ign", 300, 4, 1'b1);
      spot("ign", 400, mh[400]);
      spot("ign", 300, mh[300]);

      // randomized writes and craters
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 2) == 0)
            do_wr($sformatf("rwr%0d", k), $urandom_range(0, NC - 1), $urandom_range(0, NR - 1));
         else
            do_crater($sformatf("rcr%0d", k), $urandom_range(0, 700), $urandom_range(0, 63), 1'b0);
      end
      sweep("rand");

      // seeded noise maps
      sd = 16'($urandom_range(1, 65535));
      do_gen("noise", 1'b1, sd);
      sweep("noise");
      props("noise");
      do_gen("seed0", 1'b1, 16'h0000);
      sweep("seed0");

      // reset during a crater aborts it and regenerates
      bus.crater_start  = 1'b1;
      bus.crater_col    = 10'd300;
      bus.crater_radius = 6'd20;
      step();
      clear_req();
      chk_eq("rstcr_busy1", int'(bus.busy), 1);
      step();
      chk_eq("rstcr_busy2", int'(bus.busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_eq("rstcr_busy3", int'(bus.busy), 1);
      chk_eq("rstcr_done3", int'(bus.done), 0);
      chk_eq("rstcr_rd3", int'(bus.rd_height), 0);
      pulses = 0;
      gaps   = 0;
      for (int i = 0; i < 660; i++) begin
         step();
         if (bus.done) pulses++;
         else if (!bus.busy && pulses == 0) gaps++;
      end
      chk_eq("rstcr_pulses", pulses, 1);
      chk_eq("rstcr_gaps", gaps, 0);
      chk_eq("rstcr_idle", int'(bus.busy), 0);
      model_gen(1'b1, 16'hACE1);
      sweep("rstcr");

      // explicit ACE1 seed reproduces the reset-generated map
      do_gen("ace1", 1'b1, 16'hACE1);
      sweep("ace1");
      read_col(0, v);
      chk_eq("ace1_col0", v, DEF);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
